// File: rtl/fifo_rr_scheduler.sv
// Round-robin egress scheduler: grants one FIFO read port at a time for a bounded burst
// and forwards its beats through a registered AXI-Stream-like output stage.
module fifo_rr_scheduler #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 45,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  axis_clk,
  input  logic                  axi_reset_n,
  input  logic [N_CH-1:0]       ch_vld,
  output logic [N_CH-1:0]       ch_rdy,
  input  logic [N_CH*WIDTH-1:0] ch_data,
  input  logic [N_CH-1:0]       ch_last,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [7:0]            burst_len,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [CH_W-1:0]       out_ch,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle = 2'b00, StGrant = 2'b01} state_e;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]       blen_q, blen_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;

  logic [N_CH-1:0]  req;
  logic             pick_found;
  logic [CH_W-1:0]  pick_idx;
  int unsigned      cand;
  logic             sel_vld, sel_last, sel_en, sel_rdy, hs;
  logic [WIDTH-1:0] sel_data;
  logic [CH_W-1:0]  next_ptr;

  assign req = ch_vld & ch_en;

  // First requester at or above rr_ptr, wrapping modulo N_CH.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = (32'(rr_ptr_q) + i) % N_CH;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(cand);
      end
    end
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_en   = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == grant_q) begin
        sel_vld  = ch_vld[i];
        sel_last = ch_last[i];
        sel_en   = ch_en[i];
        sel_data = ch_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Accept only when the output register is empty or draining this cycle.
  assign sel_rdy = (state_q == StGrant) && sel_en && (!out_vld_q || out_rdy);
  assign hs      = sel_rdy && sel_vld;

  always_comb begin
    ch_rdy = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == grant_q) begin
        ch_rdy[i] = sel_rdy;
      end
    end
  end

  assign next_ptr = (32'(grant_q) == N_CH - 1) ? '0 : grant_q + CH_W'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    blen_d     = blen_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          blen_d     = (burst_len == 8'd0) ? 8'd1 : burst_len;
          beat_cnt_d = 8'd0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if ((hs && (sel_last || beat_cnt_q == blen_q - 8'd1)) || !sel_en) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_ch_d   = out_ch_q;
    if (hs) begin
      out_vld_d  = 1'b1;
      out_data_d = sel_data;
      out_last_d = sel_last;
      out_ch_d   = grant_q;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axi_reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      blen_q     <= 8'd1;
      beat_cnt_q <= 8'd0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      blen_q     <= blen_d;
      beat_cnt_q <= beat_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_ch_q   <= out_ch_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_ch   = out_ch_q;
  assign busy     = (state_q == StGrant);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: per-channel FIFO source models feed the DUT and
// the accepted handshakes / output beats are compared against hand-derived timelines.
module tb_fifo_rr_scheduler;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned WIDTH = 45;
  localparam int unsigned CH_W  = 2;

  logic                  clk = 1'b0;
  logic                  axi_reset_n;
  logic [N_CH-1:0]       ch_vld;
  logic [N_CH-1:0]       ch_rdy;
  logic [N_CH*WIDTH-1:0] ch_data;
  logic [N_CH-1:0]       ch_last;
  logic [N_CH-1:0]       ch_en;
  logic [7:0]            burst_len;
  logic                  out_vld;
  logic                  out_rdy;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [CH_W-1:0]       out_ch;
  logic                  busy;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .axis_clk   (clk),
    .axi_reset_n(axi_reset_n),
    .ch_vld     (ch_vld),
    .ch_rdy     (ch_rdy),
    .ch_data    (ch_data),
    .ch_last    (ch_last),
    .ch_en      (ch_en),
    .burst_len  (burst_len),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ch     (out_ch),
    .busy       (busy)
  );

  int src_rem[N_CH];
  int src_seq[N_CH];
  int src_last_at[N_CH];
  int cyc;
  int hs_cyc[$];
  int hs_ch[$];
  int ob_ch[$];
  int ob_last[$];
  logic [63:0] ob_data[$];
  int n_checks = 0;
  int n_pass   = 0;

  int t1_hs[10]  = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
  int t2_ch[10]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int t2_seq[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
  int t4_ch[4]   = '{0, 1, 2, 2};
  int t4_seq[4]  = '{0, 0, 0, 1};

  function automatic logic [WIDTH-1:0] dval(int c, int s);
    return WIDTH'(c * 65536 + s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N_CH; i++) begin
      ch_vld[i]                  = (src_rem[i] > 0);
      ch_data[i*WIDTH +: WIDTH]  = dval(i, src_seq[i]);
      ch_last[i]                 = (src_seq[i] == src_last_at[i]);
    end
  endtask

  // Sample handshakes 1 ns before the edge, then advance sources 1 ns after it.
  task automatic cycle();
    logic [N_CH-1:0] adv;
    @(negedge clk);
    #4;
    adv = ch_vld & ch_rdy;
    for (int i = 0; i < N_CH; i++) begin
      if (adv[i] === 1'b1) begin
        hs_cyc.push_back(cyc);
        hs_ch.push_back(i);
      end
    end
    if (out_vld === 1'b1 && out_rdy === 1'b1) begin
      ob_ch.push_back(int'(out_ch));
      ob_last.push_back(int'(out_last));
      ob_data.push_back(64'(out_data));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_CH; i++) begin
      if (adv[i] === 1'b1) begin
        src_seq[i]++;
        src_rem[i]--;
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N_CH; i++) begin
      src_rem[i]     = 0;
      src_seq[i]     = 0;
      src_last_at[i] = -1;
    end
    drive();
    axi_reset_n = 1'b0;
    cycle();
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ch_rdy", 64'(ch_rdy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    axi_reset_n = 1'b1;
    cyc = 0;
    hs_cyc.delete();
    hs_ch.delete();
    ob_ch.delete();
    ob_last.delete();
    ob_data.delete();
  endtask

  initial begin
    axi_reset_n = 1'b0;
    ch_en       = '1;
    burst_len   = 8'd4;
    out_rdy     = 1'b1;
    ch_vld      = '0;
    ch_data     = '0;
    ch_last     = '0;
    cyc         = 0;

    // Single channel, 10 beats, bursts of 4: grants 4/4/2 with one dead cycle between.
    do_reset();
    burst_len      = 8'd4;
    src_rem[0]     = 10;
    src_last_at[0] = 9;
    drive();
    #1;
    repeat (16) cycle();
    chk("t1_hs_count", 64'(hs_cyc.size()), 64'd10);
    for (int k = 0; k < 10; k++) chk($sformatf("t1_hs_cyc%0d", k), 64'(hs_cyc[k]), 64'(t1_hs[k]));
    chk("t1_ob_count", 64'(ob_ch.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_ob_ch%0d", k), 64'(ob_ch[k]), 64'd0);
      chk($sformatf("t1_ob_last%0d", k), 64'(ob_last[k]), (k == 9) ? 64'd1 : 64'd0);
      chk($sformatf("t1_ob_data%0d", k), ob_data[k], 64'(dval(0, k)));
    end

    // All channels valid, bursts of 2: round-robin 0,1,2,3,0.
    do_reset();
    burst_len = 8'd2;
    for (int i = 0; i < N_CH; i++) src_rem[i] = 100;
    drive();
    #1;
    repeat (18) cycle();
    chk("t2_ob_enough", 64'(ob_ch.size() >= 10), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t2_ob_ch%0d", k), 64'(ob_ch[k]), 64'(t2_ch[k]));
      chk($sformatf("t2_ob_data%0d", k), ob_data[k], 64'(dval(t2_ch[k], t2_seq[k])));
    end

    // Backpressure for 5 cycles mid-burst.
    do_reset();
    burst_len      = 8'd8;
    src_rem[0]     = 6;
    src_last_at[0] = 5;
    drive();
    #1;
    repeat (3) cycle();
    out_rdy = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_bp_ch_rdy%0d", k), 64'(ch_rdy), 64'd0);
      chk($sformatf("t3_bp_out_vld%0d", k), 64'(out_vld), 64'd1);
      chk($sformatf("t3_bp_out_data%0d", k), 64'(out_data), 64'(dval(0, 1)));
      cycle();
    end
    out_rdy = 1'b1;
    #1;
    repeat (10) cycle();
    chk("t3_ob_count", 64'(ob_ch.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_ob_data%0d", k), ob_data[k], 64'(dval(0, k)));
      chk($sformatf("t3_ob_last%0d", k), 64'(ob_last[k]), (k == 5) ? 64'd1 : 64'd0);
    end

    // Disable channel 1 while granted and idle: abort, then channel 2 is served.
    do_reset();
    burst_len      = 8'd4;
    src_rem[0]     = 1;
    src_last_at[0] = 0;
    src_rem[1]     = 1;
    src_rem[2]     = 2;
    src_last_at[2] = 1;
    drive();
    #1;
    repeat (4) cycle();
    chk("t4_hold_busy", 64'(busy), 64'd1);
    chk("t4_hold_ch_rdy", 64'(ch_rdy), 64'b0010);
    cycle();
    chk("t4_hold2_busy", 64'(busy), 64'd1);
    ch_en      = 4'b1101;
    src_rem[1] = 3;
    drive();
    #1;
    chk("t4_dis_ch_rdy", 64'(ch_rdy), 64'd0);
    cycle();
    chk("t4_release_busy", 64'(busy), 64'd0);
    cycle();
    chk("t4_next_ch_rdy", 64'(ch_rdy), 64'b0100);
    repeat (6) cycle();
    chk("t4_end_busy", 64'(busy), 64'd0);
    chk("t4_end_ch_rdy", 64'(ch_rdy), 64'd0);
    chk("t4_ob_count", 64'(ob_ch.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_ob_ch%0d", k), 64'(ob_ch[k]), 64'(t4_ch[k]));
      chk($sformatf("t4_ob_data%0d", k), ob_data[k], 64'(dval(t4_ch[k], t4_seq[k])));
    end
    ch_en = '1;

    // burst_len 0 behaves as 1.
    do_reset();
    burst_len  = 8'd0;
    src_rem[0] = 3;
    drive();
    #1;
    repeat (7) cycle();
    chk("t5a_hs_count", 64'(hs_cyc.size()), 64'd3);
    chk("t5a_hs0", 64'(hs_cyc[0]), 64'd1);
    chk("t5a_hs1", 64'(hs_cyc[1]), 64'd3);
    chk("t5a_hs2", 64'(hs_cyc[2]), 64'd5);

    // burst_len raised mid-grant only applies to the next grant.
    do_reset();
    burst_len  = 8'd3;
    src_rem[0] = 10;
    drive();
    #1;
    repeat (2) cycle();
    burst_len = 8'd8;
    #1;
    repeat (6) cycle();
    chk("t5b_hs_count", 64'(hs_cyc.size()), 64'd6);
    chk("t5b_hs2", 64'(hs_cyc[2]), 64'd3);
    chk("t5b_hs3", 64'(hs_cyc[3]), 64'd5);
    chk("t5b_hs5", 64'(hs_cyc[5]), 64'd7);

    // Reset during channel 1's grant with a pending beat; arbitration restarts at 0.
    do_reset();
    burst_len = 8'd2;
    for (int i = 0; i < N_CH; i++) src_rem[i] = 100;
    drive();
    #1;
    repeat (5) cycle();
    out_rdy = 1'b0;
    #1;
    chk("t6_pre_busy", 64'(busy), 64'd1);
    chk("t6_pre_out_vld", 64'(out_vld), 64'd1);
    chk("t6_pre_out_ch", 64'(out_ch), 64'd1);
    axi_reset_n = 1'b0;
    cycle();
    chk("t6_rst_out_vld", 64'(out_vld), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ch_rdy", 64'(ch_rdy), 64'd0);
    axi_reset_n = 1'b1;
    out_rdy     = 1'b1;
    #1;
    cycle();
    chk("t6_restart_busy", 64'(busy), 64'd1);
    chk("t6_restart_ch_rdy", 64'(ch_rdy), 64'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
